// File: rtl/looper_pkg.sv
// Shared definitions for the multitrack step looper: mode codes, FSM states
// and the width helper used to size step counters.
package looper_pkg;

    localparam logic [1:0] MODE_PLAY    = 2'b00;
    localparam logic [1:0] MODE_OVERDUB = 2'b01;
    localparam logic [1:0] MODE_REPLACE = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT_CLR = 2'd0,
        ST_IDLE     = 2'd1,
        ST_RUN      = 2'd2,
        ST_CLR      = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/looper_track_mem.sv
// One track of note storage: synchronous write, registered read that returns
// the data being written when both ports hit the same step.
module looper_track_mem #(
    parameter int STEPS  = 128,
    parameter int NOTE_W = 8,
    parameter int STEP_W = 7
) (
    input  logic              rateClock,
    input  logic              i_we,
    input  logic [STEP_W-1:0] i_waddr,
    input  logic [NOTE_W-1:0] i_wdata,
    input  logic [STEP_W-1:0] i_raddr,
    output logic [NOTE_W-1:0] o_rdata
);

    logic [NOTE_W-1:0] r_mem [STEPS];
    logic [NOTE_W-1:0] r_rdata;

    always_ff @(posedge rateClock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_we && (i_waddr == i_raddr)) r_rdata <= i_wdata;
        else                              r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/multitrack_step_looper.sv
// Multitrack step looper: step counter with latched loop length, per-track
// note memories with overdub/replace recording, mute, and self-clearing sweeps.
module multitrack_step_looper
    import looper_pkg::*;
#(
    parameter int TRACKS = 8,
    parameter int STEPS  = 128,
    parameter int NOTE_W = 8,
    parameter int STEP_W = clog2(STEPS)
) (
    input  logic                     rateClock,
    input  logic                     reset,
    input  logic                     run,
    input  logic [1:0]               mode,
    input  logic [TRACKS-1:0]        arm,
    input  logic [TRACKS-1:0]        mute,
    input  logic                     clear_req,
    input  logic [STEP_W-1:0]        loop_len,
    input  logic [NOTE_W-1:0]        note_in,
    output logic [STEP_W-1:0]        step_idx,
    output logic [TRACKS*NOTE_W-1:0] notes_out,
    output logic                     bar_start,
    output logic                     clearing,
    output logic [1:0]               o_state
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEP_W-1:0]   r_ptr;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   r_len;
    logic [TRACKS-1:0]   r_show;
    logic [TRACKS-1:0]   r_clr_mask;

    logic                w_sweeping;
    logic                w_sweep_done;
    logic                w_rec;
    logic [TRACKS-1:0]   w_we;
    logic [STEP_W-1:0]   w_waddr;
    logic [NOTE_W-1:0]   w_wdata;
    logic [NOTE_W-1:0]   w_rd [TRACKS];

    assign w_sweeping   = (r_state == ST_INIT_CLR) || (r_state == ST_CLR);
    assign w_sweep_done = (r_ptr == LAST_STEP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT_CLR: if (w_sweep_done) w_state_nxt = run ? ST_RUN : ST_IDLE;
            ST_IDLE: begin
                if (clear_req)  w_state_nxt = ST_CLR;
                else if (run)   w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (clear_req)  w_state_nxt = ST_CLR;
                else if (!run)  w_state_nxt = ST_IDLE;
            end
            ST_CLR:      if (w_sweep_done) w_state_nxt = run ? ST_RUN : ST_IDLE;
            default:     w_state_nxt = ST_INIT_CLR;
        endcase
    end

    always_comb begin
        w_rec = 1'b0;
        case (mode)
            MODE_PLAY:    w_rec = 1'b0;
            MODE_OVERDUB: w_rec = (note_in != '0);
            MODE_REPLACE: w_rec = 1'b1;
            default:      w_rec = 1'b0;
        endcase
    end

    always_ff @(posedge rateClock) begin
        if (!reset) begin
            r_state    <= ST_INIT_CLR;
            r_ptr      <= '0;
            r_step     <= '0;
            r_len      <= LAST_STEP;
            r_show     <= '0;
            r_clr_mask <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_sweeping ? r_ptr + 1'b1 : '0;
            // Output only continues from memory while the looper stays in RUN.
            r_show  <= ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) ? ~mute : '0;
            if ((w_state_nxt == ST_CLR) && (r_state != ST_CLR)) r_clr_mask <= arm;
            case (r_state)
                ST_RUN: begin
                    if (clear_req) begin
                        r_step <= '0;
                    end else if (run) begin
                        if (r_step == r_len) begin
                            r_step <= '0;
                            r_len  <= loop_len;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                ST_IDLE: if (clear_req) r_step <= '0;
                default: r_step <= '0;
            endcase
        end
    end

    assign w_waddr = w_sweeping ? r_ptr : r_step;
    assign w_wdata = w_sweeping ? '0 : note_in;

    for (genvar t = 0; t < TRACKS; t++) begin : g_track
        assign w_we[t] = w_sweeping ? ((r_state == ST_INIT_CLR) || r_clr_mask[t])
                                    : ((r_state == ST_RUN) && w_rec && arm[t]);

        looper_track_mem #(
            .STEPS  (STEPS),
            .NOTE_W (NOTE_W),
            .STEP_W (STEP_W)
        ) u_mem (
            .rateClock (rateClock),
            .i_we      (w_we[t]),
            .i_waddr   (w_waddr),
            .i_wdata   (w_wdata),
            .i_raddr   (r_step),
            .o_rdata   (w_rd[t])
        );

        assign notes_out[t*NOTE_W +: NOTE_W] = r_show[t] ? w_rd[t] : '0;
    end

    assign step_idx  = r_step;
    assign bar_start = (r_state == ST_RUN) && (r_step == '0);
    assign clearing  = w_sweeping;
    assign o_state   = r_state;

endmodule

// File: tb/tb_multitrack_step_looper.sv
// Self-checking bench for multitrack_step_looper: directed table, corner-case
// sequences and randomized traffic against a behavioural loop model.
module tb_multitrack_step_looper;
    import looper_pkg::*;

    localparam int TRACKS = 8;
    localparam int STEPS  = 128;
    localparam int NOTE_W = 8;
    localparam int STEP_W = 7;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     run;
    logic [1:0]               mode;
    logic [TRACKS-1:0]        arm;
    logic [TRACKS-1:0]        mute;
    logic                     clear_req;
    logic [STEP_W-1:0]        loop_len;
    logic [NOTE_W-1:0]        note_in;
    logic [STEP_W-1:0]        step_idx;
    logic [TRACKS*NOTE_W-1:0] notes_out;
    logic                     bar_start;
    logic                     clearing;
    logic [1:0]               o_state;

    int vectors = 0;
    int fails   = 0;

    multitrack_step_looper #(
        .TRACKS (TRACKS),
        .STEPS  (STEPS),
        .NOTE_W (NOTE_W)
    ) dut (
        .rateClock (clk),
        .reset     (reset),
        .run       (run),
        .mode      (mode),
        .arm       (arm),
        .mute      (mute),
        .clear_req (clear_req),
        .loop_len  (loop_len),
        .note_in   (note_in),
        .step_idx  (step_idx),
        .notes_out (notes_out),
        .bar_start (bar_start),
        .clearing  (clearing),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;

    // Reference model: memories as plain arrays, loop described by a
    // remaining-sweep counter and a running flag.
    logic [NOTE_W-1:0] m_mem [TRACKS][STEPS];
    logic [NOTE_W-1:0] m_notes [TRACKS];
    int                m_sweep_left;
    logic [TRACKS-1:0] m_mask;
    bit                m_running;
    int                m_step;
    int                m_len;

    task automatic model_step();
        if (!reset) begin
            m_sweep_left = STEPS;
            m_mask       = '1;
            m_running    = 1'b0;
            m_step       = 0;
            m_len        = STEPS - 1;
            for (int t = 0; t < TRACKS; t++) m_notes[t] = '0;
        end else if (m_sweep_left > 0) begin
            for (int t = 0; t < TRACKS; t++) begin
                if (m_mask[t]) m_mem[t][STEPS - m_sweep_left] = '0;
                m_notes[t] = '0;
            end
            m_sweep_left--;
            m_step = 0;
            if (m_sweep_left == 0) m_running = run;
        end else begin
            if (m_running)
                for (int t = 0; t < TRACKS; t++)
                    if (arm[t] && ((mode == 2'b01 && note_in != 0) || mode == 2'b10))
                        m_mem[t][m_step] = note_in;
            if (clear_req) begin
                m_sweep_left = STEPS;
                m_mask       = arm;
                m_step       = 0;
                m_running    = 1'b0;
                for (int t = 0; t < TRACKS; t++) m_notes[t] = '0;
            end else if (m_running && run) begin
                for (int t = 0; t < TRACKS; t++)
                    m_notes[t] = mute[t] ? '0 : m_mem[t][m_step];
                if (m_step == m_len) begin
                    m_step = 0;
                    m_len  = int'(loop_len);
                end else begin
                    m_step++;
                end
            end else begin
                m_running = run && !m_running ? 1'b1 : 1'b0;
                for (int t = 0; t < TRACKS; t++) m_notes[t] = '0;
            end
        end
    endtask

    function automatic logic [63:0] model_notes();
        logic [63:0] p;
        for (int t = 0; t < TRACKS; t++) p[t*NOTE_W +: NOTE_W] = m_notes[t];
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("step_idx", 64'(step_idx), 64'(m_step));
        check("notes_out", notes_out, model_notes());
        check("bar_start", 64'(bar_start), 64'(m_running && m_sweep_left == 0 && m_step == 0));
        check("clearing", 64'(clearing), 64'(m_sweep_left > 0));
        check("in_run", 64'(o_state == ST_RUN), 64'(m_running));
    endtask

    task automatic count_clearing(output int n);
        n = 0;
        while (clearing === 1'b1 && n < 400) begin
            cycle();
            n++;
        end
    endtask

    task automatic run_until_step(input int target);
        int n;
        n = 0;
        while (int'(step_idx) != target && n < 300) begin
            cycle();
            n++;
        end
        if (n >= 300) begin
            vectors++;
            fails++;
            $display("FAIL wait_step: step_idx %0d never reached %0d", step_idx, target);
        end
    endtask

    typedef struct {
        logic [1:0]        mode;
        logic [TRACKS-1:0] arm;
        logic [NOTE_W-1:0] note;
        logic [STEP_W-1:0] exp_step;
        logic              exp_bar;
        logic [NOTE_W-1:0] exp_n0;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, prev, nz0, nz3;

        tbl[0] = '{2'b01, 8'h01, 8'h00, 7'd1,  1'b0, 8'h00};
        tbl[1] = '{2'b01, 8'h01, 8'h00, 7'd2,  1'b0, 8'h00};
        tbl[2] = '{2'b01, 8'h01, 8'h00, 7'd3,  1'b0, 8'h00};
        tbl[3] = '{2'b01, 8'h01, 8'h00, 7'd4,  1'b0, 8'h00};
        tbl[4] = '{2'b01, 8'h01, 8'h00, 7'd5,  1'b0, 8'h00};
        tbl[5] = '{2'b01, 8'h01, 8'h2A, 7'd6,  1'b0, 8'h2A};
        tbl[6] = '{2'b01, 8'h01, 8'h2A, 7'd7,  1'b0, 8'h2A};
        tbl[7] = '{2'b01, 8'h01, 8'h2A, 7'd8,  1'b0, 8'h2A};
        tbl[8] = '{2'b01, 8'h01, 8'h00, 7'd9,  1'b0, 8'h00};
        tbl[9] = '{2'b01, 8'h01, 8'h00, 7'd10, 1'b0, 8'h00};

        for (int t = 0; t < TRACKS; t++)
            for (int s = 0; s < STEPS; s++) m_mem[t][s] = '0;
        for (int t = 0; t < TRACKS; t++) m_notes[t] = '0;
        m_sweep_left = STEPS; m_mask = '1; m_running = 1'b0; m_step = 0; m_len = STEPS - 1;

        reset = 1'b0; run = 1'b1; mode = 2'b00; arm = '0; mute = '0;
        clear_req = 1'b0; loop_len = 7'd127; note_in = '0;

        // Reset and power-up sweep
        cycle(); cycle();
        check("rst_step", 64'(step_idx), 64'd0);
        check("rst_notes", notes_out, 64'd0);
        check("rst_bar", 64'(bar_start), 64'd0);
        check("rst_clearing", 64'(clearing), 64'd1);
        reset = 1'b1;
        count_clearing(n);
        check("init_sweep_len", 64'(n), 64'd128);
        check("init_step0", 64'(step_idx), 64'd0);
        check("init_bar", 64'(bar_start), 64'd1);

        // Directed overdub table
        for (int i = 0; i < 10; i++) begin
            mode = tbl[i].mode; arm = tbl[i].arm; note_in = tbl[i].note;
            cycle();
            check("tbl_step", 64'(step_idx), 64'(tbl[i].exp_step));
            check("tbl_bar", 64'(bar_start), 64'(tbl[i].exp_bar));
            check("tbl_n0", 64'(notes_out[7:0]), 64'(tbl[i].exp_n0));
            check("tbl_rest", 64'(notes_out[63:8]), 64'd0);
        end

        // Overdub with silence keeps data on the next pass
        note_in = '0;
        run_until_step(8);
        check("overdub_keep", 64'(notes_out[7:0]), 64'h2A);

        // Replace with silence erases the track over a full loop
        run_until_step(0);
        mode = 2'b10;
        repeat (STEPS) cycle();
        mode = 2'b00;
        nz0 = 0;
        repeat (STEPS) begin
            cycle();
            if (notes_out[7:0] != 0) nz0++;
        end
        check("replace_erased", 64'(nz0), 64'd0);

        // Record track 3 at steps 2..4, track 0 at steps 5..7
        run_until_step(2);
        mode = 2'b01; arm = 8'h08; note_in = 8'h33;
        repeat (3) cycle();
        arm = 8'h01; note_in = 8'h2A;
        repeat (3) cycle();
        arm = '0; note_in = '0; mode = 2'b00;

        // Loop length change mid-loop takes effect only at wrap
        run_until_step(40);
        loop_len = 7'd15;
        n = 0;
        do begin
            prev = int'(step_idx);
            cycle();
            n++;
        end while (step_idx != 0 && n < 300);
        check("wrap_from", 64'(prev), 64'd127);
        for (int b = 0; b < 3; b++) begin
            n = 0;
            do begin
                cycle();
                n++;
            end while (!bar_start && n < 100);
            check("bar_period", 64'(n), 64'd16);
        end

        // Clear track 3 only; arm changes during the sweep must not matter
        arm = 8'h08; clear_req = 1'b1;
        cycle();
        clear_req = 1'b0; arm = 8'hFF;
        count_clearing(n);
        arm = '0;
        check("clr_sweep_len", 64'(n), 64'd128);
        check("clr_step0", 64'(step_idx), 64'd0);
        nz0 = 0; nz3 = 0;
        repeat (16) begin
            cycle();
            if (notes_out[7:0] != 0) nz0++;
            if (notes_out[31:24] != 0) nz3++;
        end
        check("clr_track0_kept", 64'(nz0), 64'd3);
        check("clr_track3_empty", 64'(nz3), 64'd0);

        // Mute hides track 0, unmute restores it on the next cycle
        mute = 8'h01;
        nz0 = 0;
        repeat (16) begin
            cycle();
            if (notes_out[7:0] != 0) nz0++;
        end
        check("muted", 64'(nz0), 64'd0);
        run_until_step(6);
        mute = '0;
        cycle();
        check("unmute", 64'(notes_out[7:0]), 64'h2A);

        // Randomized traffic against the model
        repeat (800) begin
            reset     = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            run       = ($urandom_range(0, 9) != 0);
            mode      = 2'($urandom_range(0, 3));
            arm       = 8'($urandom_range(0, 255));
            mute      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            clear_req = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) loop_len = 7'($urandom_range(0, 127));
            note_in   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            cycle();
        end

        // Reset in the middle of a clear sweep restarts a full sweep
        reset = 1'b1; run = 1'b1; clear_req = 1'b0; arm = 8'h0F; mode = 2'b00;
        count_clearing(n);
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        repeat (60) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        count_clearing(n);
        check("reset_resweep_len", 64'(n), 64'd128);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/multitrack_step_looper.md
Name: multitrack_step_looper

Overview:
- Parametrised successor to the fixed 8-track, 128-step looper.
- Owns its own step counter with a programmable loop length, plus per-track note memory.
- Supports overdub, replace and mute modes, and performs a self-clearing sweep.
- Advances one step per rateClock tick (rateClock comes from the rate divider); feeds notes_out to audio_out and the LED/HEX logic.

Parameters:
- TRACKS, 8: number of independent tracks.
- STEPS, 128: steps per track memory; power of two, at least 4.
- NOTE_W, 8: note code width; code 0 means silence.

Ports:
- rateClock  in  1  step clock; one step per rising edge.
- reset  in  1  synchronous, active-low.
- run  in  1  1 = advance steps; 0 = hold the current step.
- mode  in  2  00 PLAY, 01 OVERDUB, 10 REPLACE, 11 PLAY.
- arm  in  TRACKS  per-track record/clear enable.
- mute  in  TRACKS  per-track output mute.
- clear_req  in  1  single-cycle request to erase the armed tracks.
- loop_len  in  STEP_W  loop length minus 1; STEP_W = clog2(STEPS).
- note_in  in  NOTE_W  live note from the keyboard decoder.
- step_idx  out  STEP_W  current step.
- notes_out  out  TRACKS*NOTE_W  registered notes; track t occupies bits [t*NOTE_W +: NOTE_W].
- bar_start  out  1  high for the cycle in which step_idx == 0 while in RUN.
- clearing  out  1  high while a sweep is in progress.

Behaviour:
- Interface: reset is synchronous, active-low; the clock is rateClock.
- All state updates on posedge rateClock.
- FSM states: INIT_CLR, IDLE, RUN, CLR.
- Reset (reset == 0), outputs: step_idx = 0, notes_out = 0, bar_start = 0, clearing = 1.
- Reset, internal state: state = INIT_CLR, sweep pointer = 0, len_q = STEPS-1.
- Memory has no reset port. It is erased by sweeping.
- INIT_CLR: each cycle writes 0 at the sweep pointer in every track, then increments the pointer. After exactly STEPS cycles:
  - clearing falls;
  - go to RUN if run = 1, else IDLE.
- IDLE:
  - Step is held and notes_out = 0.
  - run = 1 → RUN, with step_idx kept.
  - clear_req = 1 → CLR.
- RUN, step advance:
  - step_idx increments each cycle while run = 1.
  - When step_idx == len_q, the next step is 0 and len_q <= loop_len. The new length is latched only at wrap.
- RUN, run = 0: → IDLE.
- RUN, writes:
  - OVERDUB: for each armed track, write note_in at step_idx only if note_in != 0.
  - REPLACE: for each armed track, write note_in unconditionally, so 0 erases.
  - PLAY: no writes.
- RUN, read:
  - notes_out[t] is the memory at step_idx, registered (1 cycle latency relative to step_idx).
  - Same-cycle write to that location: notes_out[t] shows the written value (write-first bypass).
  - Muted tracks output 0 but keep recording.
- CLR:
  - Sweep as INIT_CLR, but only armed tracks are written (arm is sampled at entry).
  - step_idx is forced to 0 and notes_out = 0.
  - On completion, go to RUN if run = 1, else IDLE.
- Priority in RUN/IDLE: clear_req > run. A clear_req during INIT_CLR or CLR is ignored.
- Reset during any sweep restarts INIT_CLR from pointer 0.
- loop_len >= STEPS is impossible by width. loop_len = 0 gives a single-step loop with bar_start permanently high in RUN.
- Arithmetic: step and sweep pointer are unsigned STEP_W wrap counters; the sweep-done compare is made on pointer == STEPS-1.

Decomposition:
- Package looper_pkg holds:
  - the mode encodings MODE_PLAY, MODE_OVERDUB, MODE_REPLACE;
  - the FSM state enum;
  - the step-width function clog2.
- Sub-module looper_track_mem: one track of STEPS x NOTE_W storage.
  - Inputs: write enable, write address, write data, read address.
  - Output: registered read with write-first bypass.
  - Instantiated TRACKS times via generate.

Test Plan:
- Reset pulse then run = 1 → clearing high for 128 cycles; then step_idx counts 0,1,2…; all notes_out = 0; bar_start is high at step 0.
- mode = OVERDUB, arm = 8'h01, note_in = 8'h2A at steps 5..7, then note_in = 0 → after wrap, track 0 reads 2A at steps 5–7 (1-cycle latency); other tracks read 0.
- OVERDUB over existing data with note_in = 0 leaves the data intact. REPLACE with arm = 8'h01 and note_in = 0 across a full loop → track 0 all zero on the next pass.
- loop_len changed from 127 to 15 mid-loop at step 40 → counting continues to 127, wraps, then 0..15 repeating; bar_start every 16 cycles.
- Data in tracks 0 and 3, arm = 8'h08, clear_req pulse → clearing high 128 cycles; afterwards track 3 is empty, track 0 is intact, and step restarts at 0.
- mute = 8'h01 with data recorded → track 0 slice reads 0; unmute → data reappears the next cycle. Reset asserted at sweep pointer 60 → sweep restarts and clearing is high for a further 128 cycles.
